axil_logic_regbank: RTL and testbench

Parametrised AXI4-Lite slave register bank with a built-in logic unit. It is the successor to the fixed four-register logic-module slave: register count and data width are configurable, WSTRB is honoured, and out-of-range or read-only accesses return SLVERR. Operand and control registers drive a registered bitwise ALU whose result is readable over AXI and exported to fabric. It sits behind the PS AXI interconnect (or the AXI VIP master in simulation).

---
 rtl/axil_logic_regbank_if.sv | 55 +++++
 rtl/axil_logic_regbank.sv | 209 ++++++++++++++++++++
 tb/tb_axil_logic_regbank.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_logic_regbank_if.sv
// AXI4-Lite slave bus bundle for axil_logic_regbank.
// Carries the five AXI4-Lite channels (AW, W, B, AR, R) under their original
// S_AXI_* names. Clock and reset are not part of the bundle.
//   slave  : view used by the register bank
//   master : view used by the interconnect / bus functional model
interface axil_logic_regbank_if #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 5
);
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [2:0]                      S_AXI_AWPROT;
  logic                            S_AXI_AWVALID;
  logic                            S_AXI_AWREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                            S_AXI_WVALID;
  logic                            S_AXI_WREADY;
  logic [1:0]                      S_AXI_BRESP;
  logic                            S_AXI_BVALID;
  logic                            S_AXI_BREADY;
  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [2:0]                      S_AXI_ARPROT;
  logic                            S_AXI_ARVALID;
  logic                            S_AXI_ARREADY;
  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]                      S_AXI_RRESP;
  logic                            S_AXI_RVALID;
  logic                            S_AXI_RREADY;

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );
endinterface

// File: rtl/axil_logic_regbank.sv
// AXI4-Lite register bank with a registered bitwise logic unit.
// Map (index = byte address >> log2(bytes per word)):
//   0 OPA (RW), 1 OPB (RW), 2 CTRL (RW, [1:0] op: AND/OR/XOR/NOT OPA),
//   3 RESULT (RO), 4..NUM_REGS-1 scratch (RW).
// Ports:
//   ACLK, ARESET   : clock, synchronous active-high reset
//   s_axi          : AXI4-Lite slave bundle (one write and one read in flight)
//   result_out     : current logic-unit result (same value as RESULT)
//   result_update  : one-cycle pulse when result_out is reloaded
module axil_logic_regbank #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS           = 8,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = $clog2(NUM_REGS) + $clog2(C_S_AXI_DATA_WIDTH/8)
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  axil_logic_regbank_if.slave           s_axi,
  output logic [C_S_AXI_DATA_WIDTH-1:0] result_out,
  output logic                          result_update
);
  localparam int unsigned DW   = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB   = DW / 8;
  localparam int unsigned LSB  = $clog2(NB);
  localparam int unsigned AW   = C_S_AXI_ADDR_WIDTH;
  localparam int unsigned IDXW = AW - LSB;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wstate_t;
  typedef enum logic {R_IDLE, R_DATA} rstate_t;

  logic [DW-1:0] regs [NUM_REGS];
  logic [DW-1:0] alu;
  logic          alu_pend;

  // Write channel state
  wstate_t         wstate;
  logic            awready_q, wready_q, bvalid_q;
  logic [1:0]      bresp_q;
  logic            aw_held, w_held;
  logic [IDXW-1:0] awidx_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   wstrb_q;

  logic            aw_fire, w_fire, wr_commit, wr_ok, wr_alu;
  logic [IDXW-1:0] wr_idx;
  logic [DW-1:0]   wr_data;
  logic [NB-1:0]   wr_strb;

  // Read channel state
  rstate_t         rstate;
  logic            arready_q, rvalid_q;
  logic [1:0]      rresp_q;
  logic [DW-1:0]   rdata_q;
  logic [IDXW-1:0] rd_idx;
  logic            rd_ok;
  logic [DW-1:0]   rd_val;

  logic unused_ok;
  assign unused_ok = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                       s_axi.S_AXI_AWADDR[LSB-1:0], s_axi.S_AXI_ARADDR[LSB-1:0]};

  // AW and W may arrive in either order; whichever is missing is taken live
  // from the bus so the write commits on the edge the second one is accepted.
  always_comb begin
    aw_fire   = s_axi.S_AXI_AWVALID & awready_q;
    w_fire    = s_axi.S_AXI_WVALID & wready_q;
    wr_idx    = aw_held ? awidx_q : s_axi.S_AXI_AWADDR[AW-1:LSB];
    wr_data   = w_held ? wdata_q : s_axi.S_AXI_WDATA;
    wr_strb   = w_held ? wstrb_q : s_axi.S_AXI_WSTRB;
    wr_commit = (wstate == W_IDLE) & (aw_held | aw_fire) & (w_held | w_fire);
    wr_ok     = (32'(wr_idx) < NUM_REGS) && (wr_idx != IDXW'(3));
    wr_alu    = wr_commit & wr_ok & (32'(wr_idx) <= 32'd2);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wstate    <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      bvalid_q  <= 1'b0;
      bresp_q   <= '0;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awidx_q   <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
    end else begin
      case (wstate)
        W_IDLE: begin
          if (aw_fire) begin
            awidx_q   <= s_axi.S_AXI_AWADDR[AW-1:LSB];
            aw_held   <= 1'b1;
            awready_q <= 1'b0;
          end
          if (w_fire) begin
            wdata_q  <= s_axi.S_AXI_WDATA;
            wstrb_q  <= s_axi.S_AXI_WSTRB;
            w_held   <= 1'b1;
            wready_q <= 1'b0;
          end
          if (wr_commit) begin
            wstate    <= W_RESP;
            bvalid_q  <= 1'b1;
            bresp_q   <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
          end
        end
        W_RESP: begin
          if (s_axi.S_AXI_BREADY) begin
            wstate    <= W_IDLE;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Slot 3 is never written here; reads of index 3 return result_out instead.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_commit && wr_ok) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (wr_idx == IDXW'(i)) begin
          for (int unsigned k = 0; k < NB; k++) begin
            if (wr_strb[k]) regs[i][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
      end
    end
  end

  always_comb begin
    case (regs[2][1:0])
      2'b00:   alu = regs[0] & regs[1];
      2'b01:   alu = regs[0] | regs[1];
      2'b10:   alu = regs[0] ^ regs[1];
      default: alu = ~regs[0];
    endcase
  end

  // Operands settle on the commit edge; the result is sampled one edge later.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      alu_pend      <= 1'b0;
      result_out    <= '0;
      result_update <= 1'b0;
    end else begin
      alu_pend      <= wr_alu;
      result_update <= alu_pend;
      if (alu_pend) result_out <= alu;
    end
  end

  always_comb begin
    rd_idx = s_axi.S_AXI_ARADDR[AW-1:LSB];
    rd_ok  = 32'(rd_idx) < NUM_REGS;
    rd_val = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (rd_idx == IDXW'(i)) rd_val = (i == 3) ? result_out : regs[i];
    end
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rstate    <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rresp_q   <= '0;
      rdata_q   <= '0;
    end else begin
      case (rstate)
        R_IDLE: begin
          if (s_axi.S_AXI_ARVALID) begin
            rstate    <= R_DATA;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= rd_ok ? RESP_OKAY : RESP_SLVERR;
          end
        end
        R_DATA: begin
          if (s_axi.S_AXI_RREADY) begin
            rstate    <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
          end
        end
        default: rstate <= R_IDLE;
      endcase
    end
  end

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = wready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = bresp_q;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RRESP   = rresp_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
endmodule

// File: tb/tb_axil_logic_regbank.sv
// Directed bench for axil_logic_regbank built with NUM_REGS=6 (32-bit data,
// 5-bit byte address, valid indices 0..5).
module tb_axil_logic_regbank;
  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [31:0] result_out;
  logic        result_update;

  int n_vec = 0;
  int n_miscmp = 0;
  int pulses = 0;

  axil_logic_regbank_if #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5)) bus ();

  axil_logic_regbank #(.C_S_AXI_DATA_WIDTH(32), .NUM_REGS(6)) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .s_axi         (bus),
    .result_out    (result_out),
    .result_update (result_update)
  );

  always #5 ACLK = ~ACLK;

  always @(posedge ACLK) if (result_update) pulses <= pulses + 1;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK); #1;
  endtask

  task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output int lat);
    bit aw_done, w_done, aw_hs, w_hs;
    int n;
    cyc();
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = data; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b1;
    aw_done = 0; w_done = 0; n = 0;
    while (!(aw_done && w_done) && n < 50) begin
      aw_hs = bus.S_AXI_AWVALID && bus.S_AXI_AWREADY;
      w_hs  = bus.S_AXI_WVALID && bus.S_AXI_WREADY;
      cyc(); n++;
      if (aw_hs) begin bus.S_AXI_AWVALID = 1'b0; aw_done = 1; end
      if (w_hs)  begin bus.S_AXI_WVALID = 1'b0;  w_done = 1; end
    end
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("wr_handshake", 64'(aw_done && w_done), 64'd1);
    lat = 0;
    while (!bus.S_AXI_BVALID && lat < 50) begin cyc(); lat++; end
    check("wr_bvalid_seen", 64'(bus.S_AXI_BVALID), 64'd1);
    resp = bus.S_AXI_BRESP;
    cyc();
    bus.S_AXI_BREADY = 1'b0;
  endtask

  task automatic axi_read(input logic [4:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    bit done, hs;
    int n;
    cyc();
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    done = 0; n = 0;
    while (!done && n < 50) begin
      hs = bus.S_AXI_ARVALID && bus.S_AXI_ARREADY;
      cyc(); n++;
      if (hs) begin bus.S_AXI_ARVALID = 1'b0; done = 1; end
    end
    bus.S_AXI_ARVALID = 1'b0;
    check("rd_handshake", 64'(done), 64'd1);
    lat = 0;
    while (!bus.S_AXI_RVALID && lat < 50) begin cyc(); lat++; end
    check("rd_rvalid_seen", 64'(bus.S_AXI_RVALID), 64'd1);
    data = bus.S_AXI_RDATA;
    resp = bus.S_AXI_RRESP;
    cyc();
    bus.S_AXI_RREADY = 1'b0;
  endtask

  task automatic wr_chk(input string tag, input logic [4:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] exp_resp);
    logic [1:0] resp;
    int lat;
    axi_write(addr, data, strb, resp, lat);
    check({tag, "_bresp"}, 64'(resp), 64'(exp_resp));
    check({tag, "_blat"}, 64'(lat), 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] addr, input logic [31:0] exp_data,
                        input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0] resp;
    int lat;
    axi_read(addr, d, resp, lat);
    check({tag, "_rdata"}, 64'(d), 64'(exp_data));
    check({tag, "_rresp"}, 64'(resp), 64'(exp_resp));
    check({tag, "_rlat"}, 64'(lat), 64'd0);
  endtask

  // ALU write: result must be loaded and result_update high in the cycle
  // after the B handshake (two edges after commit), then drop, one pulse total.
  task automatic alu_wr_chk(input string tag, input logic [4:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [31:0] exp_result);
    int p0;
    p0 = pulses;
    wr_chk(tag, addr, data, strb, 2'b00);
    check({tag, "_upd_hi"}, 64'(result_update), 64'd1);
    check({tag, "_result"}, 64'(result_out), 64'(exp_result));
    cyc();
    check({tag, "_upd_lo"}, 64'(result_update), 64'd0);
    cyc();
    check({tag, "_pulses"}, 64'(pulses - p0), 64'd1);
  endtask

  initial begin
    int p0;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b0;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESET = 1'b0;

    // Reset state
    check("rst_awready", 64'(bus.S_AXI_AWREADY), 64'd1);
    check("rst_wready",  64'(bus.S_AXI_WREADY), 64'd1);
    check("rst_arready", 64'(bus.S_AXI_ARREADY), 64'd1);
    check("rst_bvalid",  64'(bus.S_AXI_BVALID), 64'd0);
    check("rst_rvalid",  64'(bus.S_AXI_RVALID), 64'd0);
    check("rst_resps",   64'({bus.S_AXI_BRESP, bus.S_AXI_RRESP}), 64'd0);
    check("rst_rdata",   64'(bus.S_AXI_RDATA), 64'd0);
    check("rst_result",  64'(result_out), 64'd0);
    check("rst_update",  64'(result_update), 64'd0);

    // Basic map: CTRL=3 selects NOT OPA, RESULT is read-only
    wr_chk("w_opa", 5'h00, 32'd1, 4'hF, 2'b00);
    wr_chk("w_opb", 5'h04, 32'd2, 4'hF, 2'b00);
    wr_chk("w_ctrl", 5'h08, 32'd3, 4'hF, 2'b00);
    wr_chk("w_result_ro", 5'h0C, 32'd4, 4'hF, 2'b10);
    rd_chk("r_opa", 5'h00, 32'd1, 2'b00);
    rd_chk("r_opb", 5'h04, 32'd2, 2'b00);
    rd_chk("r_ctrl", 5'h08, 32'd3, 2'b00);
    rd_chk("r_result_not", 5'h0C, 32'hFFFF_FFFE, 2'b00);

    // Logic ops
    alu_wr_chk("alu_opa", 5'h00, 32'hF0F0_F0F0, 4'hF, 32'h0F0F_0F0F);
    alu_wr_chk("alu_opb", 5'h04, 32'hFF00_FF00, 4'hF, 32'h0F0F_0F0F);
    alu_wr_chk("alu_and", 5'h08, 32'h0000_0000, 4'hF, 32'hF000_F000);
    rd_chk("r_and", 5'h0C, 32'hF000_F000, 2'b00);
    alu_wr_chk("alu_or", 5'h08, 32'h0000_0001, 4'hF, 32'hFFF0_FFF0);
    rd_chk("r_or", 5'h0C, 32'hFFF0_FFF0, 2'b00);
    alu_wr_chk("alu_xor", 5'h08, 32'h1234_0002, 4'hF, 32'h0FF0_0FF0);
    rd_chk("r_ctrl_scratch", 5'h08, 32'h1234_0002, 2'b00);
    rd_chk("r_xor", 5'h0C, 32'h0FF0_0FF0, 2'b00);

    // Scratch writes leave the result alone
    p0 = pulses;
    wr_chk("w_scr4", 5'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
    repeat (3) cyc();
    check("scr_no_pulse", 64'(pulses - p0), 64'd0);
    rd_chk("r_scr4", 5'h10, 32'hDEAD_BEEF, 2'b00);

    // Byte strobes (XOR with OPB still selected)
    alu_wr_chk("alu_opa_full", 5'h00, 32'h1234_5678, 4'hF, 32'hED34_A978);
    alu_wr_chk("alu_opa_strb", 5'h00, 32'hAABB_CCDD, 4'b0101, 32'hEDBB_A9DD);
    rd_chk("r_opa_strb", 5'h00, 32'h12BB_56DD, 2'b00);
    wr_chk("w_strb0", 5'h00, 32'hFFFF_FFFF, 4'b0000, 2'b00);
    rd_chk("r_opa_strb0", 5'h00, 32'h12BB_56DD, 2'b00);

    // Out-of-range and low address bits
    rd_chk("r_oor", 5'h18, 32'h0, 2'b10);
    wr_chk("w_oor", 5'h18, 32'h5555_5555, 4'hF, 2'b10);
    wr_chk("w_oor7", 5'h1C, 32'h6666_6666, 4'hF, 2'b10);
    rd_chk("r_oor_scr4", 5'h10, 32'hDEAD_BEEF, 2'b00);
    rd_chk("r_oor_opa", 5'h00, 32'h12BB_56DD, 2'b00);
    rd_chk("r_lowbits", 5'h05, 32'hFF00_FF00, 2'b00);
    check("oor_result", 64'(result_out), 64'hEDBB_A9DD);

    // AW three cycles ahead of W, BREADY held off four cycles
    cyc();
    bus.S_AXI_AWADDR = 5'h14; bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
    cyc();
    bus.S_AXI_AWVALID = 1'b0;
    check("early_awready_lo", 64'(bus.S_AXI_AWREADY), 64'd0);
    for (int i = 0; i < 2; i++) begin
      cyc();
      check("early_no_b", 64'(bus.S_AXI_BVALID), 64'd0);
    end
    check("early_wready", 64'(bus.S_AXI_WREADY), 64'd1);
    bus.S_AXI_WDATA = 32'h0BAD_F00D; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    cyc();
    bus.S_AXI_WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("early_bvalid_hold", 64'(bus.S_AXI_BVALID), 64'd1);
      check("early_bresp", 64'(bus.S_AXI_BRESP), 64'd0);
      check("early_no_awready", 64'(bus.S_AXI_AWREADY), 64'd0);
      cyc();
    end
    bus.S_AXI_BREADY = 1'b1;
    check("early_bvalid_last", 64'(bus.S_AXI_BVALID), 64'd1);
    cyc();
    bus.S_AXI_BREADY = 1'b0;
    check("early_b_done", 64'(bus.S_AXI_BVALID), 64'd0);
    check("early_ready_back", 64'({bus.S_AXI_AWREADY, bus.S_AXI_WREADY}), 64'd3);
    rd_chk("r_scr5", 5'h14, 32'h0BAD_F00D, 2'b00);

    // Read and write of the same index in the commit cycle: read sees old data
    cyc();
    bus.S_AXI_AWADDR = 5'h14; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h2222_2222; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_ARADDR = 5'h14; bus.S_AXI_ARVALID = 1'b1;
    cyc();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0; bus.S_AXI_ARVALID = 1'b0;
    check("rw_bvalid", 64'(bus.S_AXI_BVALID), 64'd1);
    check("rw_rvalid", 64'(bus.S_AXI_RVALID), 64'd1);
    check("rw_old_data", 64'(bus.S_AXI_RDATA), 64'h0BAD_F00D);
    bus.S_AXI_BREADY = 1'b1; bus.S_AXI_RREADY = 1'b1;
    cyc();
    bus.S_AXI_BREADY = 1'b0; bus.S_AXI_RREADY = 1'b0;
    check("rw_done", 64'({bus.S_AXI_BVALID, bus.S_AXI_RVALID}), 64'd0);
    rd_chk("r_scr5_new", 5'h14, 32'h2222_2222, 2'b00);

    // Reset while a write response is pending
    cyc();
    bus.S_AXI_AWADDR = 5'h00; bus.S_AXI_AWVALID = 1'b1;
    bus.S_AXI_WDATA = 32'h0000_005A; bus.S_AXI_WSTRB = 4'hF; bus.S_AXI_WVALID = 1'b1;
    bus.S_AXI_BREADY = 1'b0;
    cyc();
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    check("arst_bvalid_pre", 64'(bus.S_AXI_BVALID), 64'd1);
    ARESET = 1'b1;
    cyc();
    check("arst_bvalid", 64'(bus.S_AXI_BVALID), 64'd0);
    ARESET = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    repeat (2) cyc();
    check("arst_no_b", 64'(bus.S_AXI_BVALID), 64'd0);
    check("arst_update", 64'(result_update), 64'd0);
    check("arst_result", 64'(result_out), 64'd0);
    bus.S_AXI_BREADY = 1'b0;
    rd_chk("arst_r0", 5'h00, 32'h0, 2'b00);
    rd_chk("arst_r1", 5'h04, 32'h0, 2'b00);
    rd_chk("arst_r2", 5'h08, 32'h0, 2'b00);
    rd_chk("arst_r3", 5'h0C, 32'h0, 2'b00);
    rd_chk("arst_r4", 5'h10, 32'h0, 2'b00);
    rd_chk("arst_r5", 5'h14, 32'h0, 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end
endmodule
